// File: rtl/image_stream_proc.sv
// Raster-order RGB888 frame reader: fetches pixels from memory, applies one
// per-pixel operation and emits an hsync-qualified stream with line blanking.
module image_stream_proc #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int HBLANK = 160,
    parameter int ADDR_W = 19
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        value,
    input  logic [7:0]        threshold,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              hsync,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, LINE, HBLK, DRAIN, DONE} state_t;

    state_t            state, next_state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [BLK_W-1:0]  blk_cnt;
    logic [ADDR_W-1:0] addr;
    logic              drain_cnt;
    logic [1:0]        mode_q;
    logic [7:0]        value_q;
    logic [7:0]        thr_q;
    logic              ren_d1;

    logic end_of_line, last_row, blk_end;
    assign end_of_line = (col == COL_W'(WIDTH - 1));
    assign last_row    = (row == ROW_W'(HEIGHT - 1));
    assign blk_end     = (blk_cnt == BLK_W'(HBLANK - 1));
    assign mem_addr    = addr;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        mem_ren    = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = LINE;
            end
            LINE: begin
                mem_ren = 1'b1;
                if (end_of_line) begin
                    if (last_row)        next_state = DRAIN;
                    else if (HBLANK > 0) next_state = HBLK;
                end
            end
            HBLK:  if (blk_end) next_state = LINE;
            DRAIN: if (drain_cnt) next_state = DONE;
            DONE: begin
                frame_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            blk_cnt   <= '0;
            addr      <= '0;
            drain_cnt <= 1'b0;
            mode_q    <= 2'b00;
            value_q   <= 8'd0;
            thr_q     <= 8'd0;
        end else begin
            state     <= next_state;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            case (state)
                IDLE: if (start) begin
                    col     <= '0;
                    row     <= '0;
                    addr    <= '0;
                    mode_q  <= mode;
                    value_q <= value;
                    thr_q   <= threshold;
                end
                LINE: begin
                    blk_cnt <= '0;
                    // Hold on the final pixel so the address never wraps.
                    if (addr != LAST_PIX) addr <= addr + ADDR_W'(1);
                    if (end_of_line) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                HBLK:    blk_cnt <= blk_cnt + BLK_W'(1);
                default: ;
            endcase
        end
    end

    function automatic logic [7:0] add_sat(input logic [7:0] c, input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, c} + {1'b0, v};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] sub_sat(input logic [7:0] c, input logic [7:0] v);
        return (c < v) ? 8'h00 : c - v;
    endfunction

    logic [7:0] pix_r, pix_g, pix_b;
    logic [7:0] res_r, res_g, res_b;
    logic [9:0] sum10, thr3;
    assign pix_r = mem_rdata[23:16];
    assign pix_g = mem_rdata[15:8];
    assign pix_b = mem_rdata[7:0];
    assign sum10 = {2'b00, pix_r} + {2'b00, pix_g} + {2'b00, pix_b};
    assign thr3  = {2'b00, thr_q} + {1'b0, thr_q, 1'b0};

    always_comb begin
        res_r = pix_r;
        res_g = pix_g;
        res_b = pix_b;
        case (mode_q)
            2'b01: begin
                res_r = add_sat(pix_r, value_q);
                res_g = add_sat(pix_g, value_q);
                res_b = add_sat(pix_b, value_q);
            end
            2'b10: begin
                res_r = sub_sat(pix_r, value_q);
                res_g = sub_sat(pix_g, value_q);
                res_b = sub_sat(pix_b, value_q);
            end
            2'b11: begin
                // Strictly greater than; equality maps to black.
                res_r = (sum10 > thr3) ? 8'hFF : 8'h00;
                res_g = res_r;
                res_b = res_r;
            end
            default: ;
        endcase
    end

    // Two-stage pipeline: ren_d1 marks the cycle mem_rdata is valid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ren_d1  <= 1'b0;
            hsync   <= 1'b0;
            DATA_R0 <= 8'd0;
            DATA_G0 <= 8'd0;
            DATA_B0 <= 8'd0;
        end else begin
            ren_d1 <= mem_ren;
            hsync  <= ren_d1;
            if (ren_d1) begin
                DATA_R0 <= res_r;
                DATA_G0 <= res_g;
                DATA_B0 <= res_b;
            end
        end
    end

endmodule

// File: tb/tb_image_stream_proc.sv
// Bench for image_stream_proc: two instances (HBLANK=3 and HBLANK=0) share
// stimulus and are compared every cycle against an arithmetic frame model.
module tb_image_stream_proc;

    localparam int W = 4;
    localparam int H = 2;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] value = 8'd0;
    logic [7:0] threshold = 8'd0;

    logic        ren_a, ren_b, hs_a, hs_b, busy_a, busy_b, done_a, done_b;
    logic [3:0]  addr_a, addr_b;
    logic [23:0] rdata_a, rdata_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic [23:0] mem [0:15];

    image_stream_proc #(.WIDTH(W), .HEIGHT(H), .HBLANK(3), .ADDR_W(4)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .mem_ren(ren_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
        .hsync(hs_a), .DATA_R0(r_a), .DATA_G0(g_a), .DATA_B0(b_a),
        .busy(busy_a), .frame_done(done_a));

    image_stream_proc #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .ADDR_W(4)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode(mode), .value(value),
        .threshold(threshold), .mem_ren(ren_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
        .hsync(hs_b), .DATA_R0(r_b), .DATA_G0(g_b), .DATA_B0(b_b),
        .busy(busy_b), .frame_done(done_b));

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (ren_a) rdata_a <= mem[addr_a];
        if (ren_b) rdata_b <= mem[addr_b];
    end

    int edge_n = 0;
    always @(posedge HCLK) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    bit          active [2];
    int          k_start [2];
    int          mode_l [2], val_l [2], thr_l [2];
    logic [23:0] last_exp [2];
    int          hs_cnt [2], done_edge [2], hs_first [2], hs_last [2];
    logic [23:0] cap [0:7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level pixel operation on plain integers.
    function automatic logic [23:0] model_px(input int md, input int v, input int th,
                                             input logic [23:0] w);
        int c [3];
        int o [3];
        c[0] = int'(w[23:16]);
        c[1] = int'(w[15:8]);
        c[2] = int'(w[7:0]);
        for (int j = 0; j < 3; j++) begin
            case (md)
                1:       o[j] = (c[j] + v > 255) ? 255 : c[j] + v;
                2:       o[j] = (c[j] - v < 0) ? 0 : c[j] - v;
                3:       o[j] = (c[0] + c[1] + c[2] > 3 * th) ? 255 : 0;
                default: o[j] = c[j];
            endcase
        end
        return {8'(o[0]), 8'(o[1]), 8'(o[2])};
    endfunction

    // Expected outputs derived from the frame timeline: read of pixel (l,c) at
    // rel = 1 + l*(W+hb) + c, output two cycles later, done right after the last.
    task automatic compare_inst(input int i, input int hb, input logic ren,
                                input logic [3:0] addr, input logic hs,
                                input logic [23:0] data, input logic bsy,
                                input logic dn);
        int t, per, done_rel, rel, r, h, idx;
        logic e_ren, e_hs, e_busy, e_done;
        int e_addr;
        logic [23:0] e_data;
        string sfx;
        sfx = (i == 0) ? "_a" : "_b";
        t = edge_n + 1;
        per = W + hb;
        done_rel = 3 + (H - 1) * per + W;
        e_ren = 0; e_hs = 0; e_busy = 0; e_done = 0; e_addr = 0;
        e_data = last_exp[i];
        rel = 0;
        if (active[i]) begin
            rel = t - k_start[i];
            r = rel - 1;
            if (r >= 0) begin
                if ((r % per) < W && (r / per) < H) begin
                    e_ren = 1;
                    e_addr = (r / per) * W + (r % per);
                end
            end
            h = rel - 3;
            if (h >= 0) begin
                if ((h % per) < W && (h / per) < H) begin
                    e_hs = 1;
                    idx = (h / per) * W + (h % per);
                    e_data = model_px(mode_l[i], val_l[i], thr_l[i], mem[idx]);
                end
            end
            e_busy = (rel >= 1) && (rel <= done_rel);
            e_done = (rel == done_rel);
        end
        check({"mem_ren", sfx}, int'(ren), int'(e_ren));
        if (e_ren) check({"mem_addr", sfx}, int'(addr), e_addr);
        check({"hsync", sfx}, int'(hs), int'(e_hs));
        check({"data", sfx}, int'(data), int'(e_data));
        check({"busy", sfx}, int'(bsy), int'(e_busy));
        check({"frame_done", sfx}, int'(dn), int'(e_done));
        if (hs) begin
            if (i == 0 && hs_cnt[i] < 8) cap[hs_cnt[i]] = data;
            if (hs_cnt[i] == 0) hs_first[i] = t;
            hs_last[i] = t;
            hs_cnt[i]++;
        end
        if (dn) done_edge[i] = t;
        if (e_hs) last_exp[i] = e_data;
        if (active[i] && rel >= done_rel) active[i] = 0;
    endtask

    always @(negedge HCLK) begin
        compare_inst(0, 3, ren_a, addr_a, hs_a, {r_a, g_a, b_a}, busy_a, done_a);
        compare_inst(1, 0, ren_b, addr_b, hs_b, {r_b, g_b, b_b}, busy_b, done_b);
    end

    // Called just after a negedge; start is sampled at the next posedge.
    task automatic pulse_start();
        int s;
        start = 1'b1;
        s = edge_n + 1;
        for (int i = 0; i < 2; i++) begin
            if (!active[i]) begin
                active[i] = 1;
                k_start[i] = s;
                mode_l[i] = int'(mode);
                val_l[i] = int'(value);
                thr_l[i] = int'(threshold);
                hs_cnt[i] = 0;
                done_edge[i] = -1;
            end
        end
        @(negedge HCLK);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [1:0] md, input logic [7:0] v, input logic [7:0] th);
        @(negedge HCLK);
        mode = md;
        value = v;
        threshold = th;
        pulse_start();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active[0] || active[1]) && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        check("frame_timeout", int'(active[0] | active[1]), 0);
        @(negedge HCLK);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hsync"}, int'(hs_a | hs_b), 0);
        check({tag, "_data_a"}, int'({r_a, g_a, b_a}), 0);
        check({tag, "_data_b"}, int'({r_b, g_b, b_b}), 0);
        check({tag, "_busy"}, int'(busy_a | busy_b), 0);
        check({tag, "_done"}, int'(done_a | done_b), 0);
        check({tag, "_ren"}, int'(ren_a | ren_b), 0);
        check({tag, "_addr"}, int'(addr_a | addr_b), 0);
    endtask

    initial begin
        int k;
        for (int n = 0; n < 16; n++)
            mem[n] = {8'(n * 10), 8'(n * 10 + 1), 8'(n * 10 + 2)};
        for (int i = 0; i < 2; i++) begin
            active[i] = 0; last_exp[i] = '0; hs_cnt[i] = 0;
            done_edge[i] = -1; hs_first[i] = 0; hs_last[i] = 0;
        end
        #1 HRESETn = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // Pass-through timing frame.
        run_frame(2'b00, 8'd0, 8'd0);
        wait_idle();
        check("done_latency_a", done_edge[0] - k_start[0], 14);
        check("done_latency_b", done_edge[1] - k_start[1], 11);
        check("pixels_a", hs_cnt[0], 8);
        check("pixels_b", hs_cnt[1], 8);
        check("hsync_span_b", hs_last[1] - hs_first[1], 7);
        check("hsync_span_a", hs_last[0] - hs_first[0], 10);
        check("pass_px0", int'(cap[0]), 24'h000102);
        check("pass_px7", int'(cap[7]), 24'h464748);

        // Saturating add.
        run_frame(2'b01, 8'd250, 8'd0);
        wait_idle();
        check("add_px0", int'(cap[0]), 24'hFAFBFC);
        check("add_px1", int'(cap[1]), 24'hFFFFFF);

        // Saturating subtract.
        run_frame(2'b10, 8'd20, 8'd0);
        wait_idle();
        check("sub_px1", int'(cap[1]), 24'h000000);
        check("sub_px7", int'(cap[7]), 24'h323334);

        // Threshold: equality is black, one above is white.
        mem[0] = 24'h646464;
        mem[1] = 24'h656464;
        run_frame(2'b11, 8'd0, 8'd100);
        wait_idle();
        check("thr_equal", int'(cap[0]), 24'h000000);
        check("thr_above", int'(cap[1]), 24'hFFFFFF);
        mem[0] = 24'h000102;
        mem[1] = 24'h0A0B0C;

        // Start and mode change while busy must be ignored.
        run_frame(2'b00, 8'd0, 8'd0);
        k = k_start[0];
        while (edge_n < k + 4) @(negedge HCLK);
        mode = 2'b01;
        value = 8'd250;
        pulse_start();
        wait_idle();
        check("ignore_px1", int'(cap[1]), 24'h0A0B0C);
        check("ignore_px5", int'(cap[5]), 24'h323334);
        check("ignore_pixels", hs_cnt[0], 8);
        check("ignore_done", done_edge[0] - k, 14);

        // Mid-frame reset clears immediately and suppresses frame_done.
        run_frame(2'b00, 8'd0, 8'd0);
        k = k_start[0];
        while (edge_n < k + 6) @(negedge HCLK);
        #3;
        HRESETn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            active[i] = 0;
            last_exp[i] = '0;
        end
        #1 check_zero_outputs("midreset");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (12) @(negedge HCLK);
        check("midreset_no_done_a", done_edge[0], -1);
        check("midreset_no_done_b", done_edge[1], -1);
        run_frame(2'b00, 8'd0, 8'd0);
        wait_idle();
        check("after_reset_pixels", hs_cnt[0], 8);
        check("after_reset_px0", int'(cap[0]), 24'h000102);
        check("after_reset_done", done_edge[0] - k_start[0], 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
